// File: rtl/sys_pkg.sv
// Shared constants and FSM encoding for the UART command front-end.
package sys_pkg;

  localparam int unsigned DATA_WIDTH_D = 8;
  localparam int unsigned ADDR_WIDTH_D = 4;
  localparam logic [7:0]  WR_CMD_D     = 8'hAA;
  localparam logic [7:0]  RD_CMD_D     = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } cmd_state_e;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Byte-framed command parser: turns UART RX bytes into register-file
// writes/reads and returns read data to the UART TX path.
module reg_cmd_ctrl
  import sys_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = DATA_WIDTH_D,
  parameter int unsigned            ADDR_WIDTH = ADDR_WIDTH_D,
  parameter logic [DATA_WIDTH-1:0]  WR_CMD     = DATA_WIDTH'(WR_CMD_D),
  parameter logic [DATA_WIDTH-1:0]  RD_CMD     = DATA_WIDTH'(RD_CMD_D),
  parameter int unsigned            TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  CMD_ERR
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  cmd_state_e            state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [CW-1:0]         cnt, cnt_n;

  logic                  wr_n, rd_n, txv_n, err_n;
  logic [ADDR_WIDTH-1:0] rf_addr_n;
  logic [DATA_WIDTH-1:0] rf_wdata_n, tx_data_n;
  logic                  addr_bad;

  // An address byte is only legal if the bits above the address field are clear
  assign addr_bad = |RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];

  // State, holding registers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt        <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      cnt        <= cnt_n;
      RF_WrEn    <= wr_n;
      RF_RdEn    <= rd_n;
      RF_Address <= rf_addr_n;
      RF_WrData  <= rf_wdata_n;
      TX_P_DATA  <= tx_data_n;
      TX_D_VLD   <= txv_n;
      CMD_ERR    <= err_n;
    end
  end

  // Next-state and next-output decode; strobes default low so each is a single-cycle pulse
  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    data_n     = data_q;
    cnt_n      = cnt;
    wr_n       = 1'b0;
    rd_n       = 1'b0;
    txv_n      = 1'b0;
    err_n      = 1'b0;
    rf_addr_n  = RF_Address;
    rf_wdata_n = RF_WrData;
    tx_data_n  = TX_P_DATA;

    unique case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_n = WR_ADDR;
          else if (RX_P_DATA == RD_CMD) state_n = RD_ADDR;
          else                          err_n   = 1'b1;
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_bad) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_n = WR_DATA;
          end
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_n       = 1'b1;
          rf_addr_n  = addr_q;
          rf_wdata_n = RX_P_DATA;
          state_n    = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_bad) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            addr_n    = RX_P_DATA[ADDR_WIDTH-1:0];
            rf_addr_n = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_n      = 1'b1;
            cnt_n     = '0;
            state_n   = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // Stray RX bytes are dropped but flagged; the read keeps going
        if (RX_D_VLD) err_n = 1'b1;
        if (RF_RdData_Valid) begin
          data_n  = RF_RdData;
          state_n = TX_SEND;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      TX_SEND: begin
        if (RX_D_VLD) err_n = 1'b1;
        if (!TX_Busy) begin
          txv_n     = 1'b1;
          tx_data_n = data_q;
          state_n   = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
